// File: rtl/control_seq.sv
// Hardwired Mini SRC control sequencer: fetch/decode/execute T-states driving
// datapath strobes and register select/encode controls, with ready-gated memory states.
module control_seq (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic        con,
   input  logic        mem_ready,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic        Cout,
   output logic        PCout,
   output logic        PCin,
   output logic        IncPC,
   output logic        MARin,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        Yin,
   output logic        Zin,
   output logic        Zlowout,
   output logic        CONin,
   output logic        Read,
   output logic        Write,
   output logic [3:0]  alu_op,
   output logic        run
);

   typedef enum logic [3:0] {
      S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_t;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_BR   = 5'b10010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;

   state_t     r_state;
   state_t     w_next;
   logic [4:0] w_op;
   logic       w_rtype, w_itype, w_ldi, w_ld, w_st, w_br, w_halt;
   logic       w_short;
   logic [3:0] w_alu_code;
   logic       w_unused_instr;

   assign w_op           = instr[31:27];
   assign w_unused_instr = ^instr[26:0];

   assign w_rtype = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_AND) || (w_op == OP_OR);
   assign w_itype = (w_op == OP_ADDI) || (w_op == OP_ANDI) || (w_op == OP_ORI);
   assign w_ldi   = (w_op == OP_LDI);
   assign w_ld    = (w_op == OP_LD);
   assign w_st    = (w_op == OP_ST);
   assign w_br    = (w_op == OP_BR);
   assign w_halt  = (w_op == OP_HALT);
   assign w_short = w_rtype || w_itype || w_ldi;

   always_comb begin
      w_alu_code = ALU_ADD;
      case (w_op)
         OP_SUB:          w_alu_code = ALU_SUB;
         OP_AND, OP_ANDI: w_alu_code = ALU_AND;
         OP_OR,  OP_ORI:  w_alu_code = ALU_OR;
         default:         w_alu_code = ALU_ADD;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) r_state <= S_RST;
      else        r_state <= w_next;
   end

   // Memory states (T1, ld T6, st T7) hold until mem_ready; nop/unknown opcodes end after T2.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_RST:  w_next = S_T0;
         S_T0:   w_next = S_T1;
         S_T1:   if (mem_ready) w_next = S_T2;
         S_T2: begin
            if (w_halt)                            w_next = S_HALT;
            else if (w_short || w_ld || w_st || w_br) w_next = S_T3;
            else                                   w_next = S_T0;
         end
         S_T3:   w_next = S_T4;
         S_T4:   w_next = S_T5;
         S_T5:   w_next = (w_ld || w_st || w_br) ? S_T6 : S_T0;
         S_T6: begin
            if (w_ld)      w_next = mem_ready ? S_T7 : S_T6;
            else if (w_st) w_next = S_T7;
            else           w_next = S_T0;
         end
         S_T7: begin
            if (w_st) w_next = mem_ready ? S_T0 : S_T7;
            else      w_next = S_T0;
         end
         S_HALT: w_next = S_HALT;
         default: w_next = S_RST;
      endcase
   end

   always_comb begin
      Gra = 1'b0;  Grb = 1'b0;  Grc = 1'b0;  Rin = 1'b0;  Rout = 1'b0;
      BAout = 1'b0; Cout = 1'b0; PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0;
      MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0;
      Zin = 1'b0;  Zlowout = 1'b0; CONin = 1'b0; Read = 1'b0; Write = 1'b0;
      alu_op = ALU_ADD;
      run = (r_state != S_RST) && (r_state != S_HALT);
      case (r_state)
         S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
         S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
         S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
         S_T3: begin
            if (w_br) begin
               Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
            end else if (w_ldi || w_ld || w_st) begin
               Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
            end else if (w_rtype || w_itype) begin
               Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
            end
         end
         S_T4: begin
            if (w_br) begin
               PCout = 1'b1; Yin = 1'b1;
            end else if (w_ldi || w_ld || w_st) begin
               Cout = 1'b1; Zin = 1'b1;
            end else if (w_rtype) begin
               Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = w_alu_code;
            end else if (w_itype) begin
               Cout = 1'b1; Zin = 1'b1; alu_op = w_alu_code;
            end
         end
         S_T5: begin
            if (w_br) begin
               Cout = 1'b1; Zin = 1'b1;
            end else if (w_ld || w_st) begin
               Zlowout = 1'b1; MARin = 1'b1;
            end else if (w_short) begin
               Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end
         end
         S_T6: begin
            if (w_ld) begin
               Read = 1'b1; MDRin = 1'b1;
            end else if (w_st) begin
               Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
            end else if (w_br && con) begin
               Zlowout = 1'b1; PCin = 1'b1;
            end
         end
         S_T7: begin
            if (w_ld) begin
               MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end else if (w_st) begin
               Write = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_seq.sv
// Self-checking bench for control_seq: a per-instruction strobe-table model drives
// lockstep expectations that one negedge process compares against the DUT.
module tb_control_seq;

   logic        clock;
   logic        reset;
   logic [31:0] instr;
   logic        con;
   logic        mem_ready;
   logic Gra, Grb, Grc, Rin, Rout, BAout, Cout;
   logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, CONin;
   logic Read, Write, run;
   logic [3:0] alu_op;

   control_seq dut (
      .clock(clock), .reset(reset), .instr(instr), .con(con), .mem_ready(mem_ready),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
      .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
      .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .CONin(CONin),
      .Read(Read), .Write(Write), .alu_op(alu_op), .run(run)
   );

   localparam logic [24:0] M_GRA   = 25'd1 << 0;
   localparam logic [24:0] M_GRB   = 25'd1 << 1;
   localparam logic [24:0] M_GRC   = 25'd1 << 2;
   localparam logic [24:0] M_RIN   = 25'd1 << 3;
   localparam logic [24:0] M_ROUT  = 25'd1 << 4;
   localparam logic [24:0] M_BAOUT = 25'd1 << 5;
   localparam logic [24:0] M_COUT  = 25'd1 << 6;
   localparam logic [24:0] M_PCOUT = 25'd1 << 7;
   localparam logic [24:0] M_PCIN  = 25'd1 << 8;
   localparam logic [24:0] M_INCPC = 25'd1 << 9;
   localparam logic [24:0] M_MARIN = 25'd1 << 10;
   localparam logic [24:0] M_MDRIN = 25'd1 << 11;
   localparam logic [24:0] M_MDROUT= 25'd1 << 12;
   localparam logic [24:0] M_IRIN  = 25'd1 << 13;
   localparam logic [24:0] M_YIN   = 25'd1 << 14;
   localparam logic [24:0] M_ZIN   = 25'd1 << 15;
   localparam logic [24:0] M_ZLOW  = 25'd1 << 16;
   localparam logic [24:0] M_CONIN = 25'd1 << 17;
   localparam logic [24:0] M_READ  = 25'd1 << 18;
   localparam logic [24:0] M_WRITE = 25'd1 << 19;
   localparam logic [24:0] M_RUN   = 25'd1 << 24;

   logic [24:0] w_got;
   assign w_got = {run, alu_op, Write, Read, CONin, Zlowout, Zin, Yin, IRin, MDRout, MDRin,
                   MARin, IncPC, PCin, PCout, Cout, BAout, Rout, Rin, Grc, Grb, Gra};

   int          n_chk = 0;
   int          n_fail = 0;
   logic        chk = 1'b0;
   logic [24:0] exp_vec = '0;
   string       tag = "init";
   int          cyc_idx = 0;
   int          rd_cnt = 0;
   int          pcin_cnt = 0;
   string       lit_nm [64];
   int          lit_got[64];
   int          lit_exp[64];
   int          lit_wr = 0;
   int          lit_rd = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, required finish before 200000 time units");
      $fatal(1, "timeout");
   end

   always @(negedge clock) begin
      if (chk) begin
         n_chk++;
         if (w_got !== exp_vec) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h required %h", tag, cyc_idx, w_got, exp_vec);
         end
         if (Read === 1'b1) rd_cnt++;
         if (PCin === 1'b1) pcin_cnt++;
      end
      while (lit_rd < lit_wr) begin
         n_chk++;
         if (lit_got[lit_rd] != lit_exp[lit_rd]) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", lit_nm[lit_rd], lit_got[lit_rd], lit_exp[lit_rd]);
         end
         lit_rd++;
      end
   end

   task automatic lit(input string nm, input int got, input int expv);
      lit_nm[lit_wr]  = nm;
      lit_got[lit_wr] = got;
      lit_exp[lit_wr] = expv;
      lit_wr++;
   endtask

   task automatic cyc(input logic rn, input logic mr, input logic cn, input logic [24:0] e);
      reset = rn; mem_ready = mr; con = cn; exp_vec = e; chk = 1'b1;
      @(posedge clock);
      #1;
      cyc_idx++;
   endtask

   // Non-memory state: mem_ready low (must be ignored), con opposite of the branch value.
   task automatic plain(input logic [24:0] e, input logic cv, inout int n);
      cyc(1'b1, 1'b0, cv, e | M_RUN);
      n++;
   endtask

   task automatic mem(input int w, input logic [24:0] e, input logic cv, inout int n);
      for (int i = 0; i < w; i++) cyc(1'b1, 1'b0, cv, e | M_RUN);
      cyc(1'b1, 1'b1, cv, e | M_RUN);
      n += w + 1;
   endtask

   function automatic logic [24:0] am(input logic [3:0] c);
      return {1'b0, c, 20'h0};
   endfunction

   task automatic exec_instr(input string name, input logic [31:0] ir, input int wf,
                             input int wm, input logic cn, output int n);
      logic [4:0] op;
      logic [3:0] code;
      logic       is_r, is_i, is_ldi, is_ld, is_st, is_br;
      logic       cv;
      tag = name; instr = ir; op = ir[31:27]; n = 0; cv = ~cn;
      is_r   = (op == 5'b00011) || (op == 5'b00100) || (op == 5'b00101) || (op == 5'b00110);
      is_i   = (op == 5'b01100) || (op == 5'b01101) || (op == 5'b01110);
      is_ldi = (op == 5'b00001);
      is_ld  = (op == 5'b00000);
      is_st  = (op == 5'b00010);
      is_br  = (op == 5'b10010);
      case (op)
         5'b00100:           code = 4'b0001;
         5'b00101, 5'b01101: code = 4'b0010;
         5'b00110, 5'b01110: code = 4'b0011;
         default:            code = 4'b0000;
      endcase
      plain(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, cv, n);
      mem(wf, M_ZLOW | M_PCIN | M_READ | M_MDRIN, cv, n);
      plain(M_MDROUT | M_IRIN, cv, n);
      if (is_r || is_i) begin
         plain(M_GRB | M_ROUT | M_YIN, cv, n);
         plain((is_r ? (M_GRC | M_ROUT) : M_COUT) | M_ZIN | am(code), cv, n);
         plain(M_ZLOW | M_GRA | M_RIN, cv, n);
      end else if (is_ldi || is_ld || is_st) begin
         plain(M_GRB | M_BAOUT | M_YIN, cv, n);
         plain(M_COUT | M_ZIN, cv, n);
         if (is_ldi) plain(M_ZLOW | M_GRA | M_RIN, cv, n);
         else begin
            plain(M_ZLOW | M_MARIN, cv, n);
            if (is_ld) begin
               mem(wm, M_READ | M_MDRIN, cv, n);
               plain(M_MDROUT | M_GRA | M_RIN, cv, n);
            end else begin
               plain(M_GRA | M_ROUT | M_MDRIN, cv, n);
               mem(wm, M_WRITE, cv, n);
            end
         end
      end else if (is_br) begin
         plain(M_GRA | M_ROUT | M_CONIN, cv, n);
         plain(M_PCOUT | M_YIN, cv, n);
         plain(M_COUT | M_ZIN, cv, n);
         cyc(1'b1, 1'b0, cn, (cn ? (M_ZLOW | M_PCIN) : 25'h0) | M_RUN);
         n++;
      end
   endtask

   initial begin
      int n;
      int r0;
      int p0;
      reset = 1'b0; mem_ready = 1'b0; con = 1'b0; instr = '0;
      repeat (2) @(posedge clock);
      #1;
      tag = "reset_idle";
      cyc(1'b0, 1'b1, 1'b1, 25'h0);
      cyc(1'b1, 1'b1, 1'b1, 25'h0);

      exec_instr("add", 32'h19890000, 0, 0, 1'b0, n); lit("add_latency", n, 6);
      exec_instr("sub",  {5'b00100, 27'h0}, 0, 0, 1'b0, n);
      exec_instr("and",  {5'b00101, 27'h0}, 1, 0, 1'b0, n); lit("and_latency_1wait", n, 7);
      exec_instr("or",   {5'b00110, 27'h0}, 0, 0, 1'b0, n);
      exec_instr("addi", {5'b01100, 27'h0}, 0, 0, 1'b0, n);
      exec_instr("andi", {5'b01101, 27'h0}, 0, 0, 1'b0, n);
      exec_instr("ori",  {5'b01110, 27'h0}, 0, 0, 1'b0, n);
      exec_instr("ldi",  {5'b00001, 27'h0}, 0, 0, 1'b0, n); lit("ldi_latency", n, 6);

      r0 = rd_cnt;
      exec_instr("ld", {5'b00000, 27'h0}, 2, 2, 1'b0, n);
      lit("ld_latency_waits", n, 12);
      lit("ld_read_cycles", rd_cnt - r0, 6);
      exec_instr("ld_nowait", {5'b00000, 27'h0}, 0, 0, 1'b0, n); lit("ld_latency", n, 8);

      exec_instr("st", {5'b00010, 27'h0}, 0, 3, 1'b0, n); lit("st_latency_waits", n, 11);
      exec_instr("st_nowait", {5'b00010, 27'h0}, 0, 0, 1'b0, n); lit("st_latency", n, 8);

      p0 = pcin_cnt;
      exec_instr("br_con1", {5'b10010, 27'h0}, 0, 0, 1'b1, n);
      lit("br_latency", n, 7);
      lit("br_con1_pcin_cycles", pcin_cnt - p0, 2);
      p0 = pcin_cnt;
      exec_instr("br_con0", {5'b10010, 27'h0}, 0, 0, 1'b0, n);
      lit("br_con0_pcin_cycles", pcin_cnt - p0, 1);

      // Reset asserted for three cycles starting in T4 of an add.
      tag = "reset_mid_add"; instr = 32'h19890000;
      cyc(1'b1, 1'b0, 1'b0, M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN);
      cyc(1'b1, 1'b1, 1'b0, M_RUN | M_ZLOW | M_PCIN | M_READ | M_MDRIN);
      cyc(1'b1, 1'b0, 1'b0, M_RUN | M_MDROUT | M_IRIN);
      cyc(1'b1, 1'b0, 1'b0, M_RUN | M_GRB | M_ROUT | M_YIN);
      cyc(1'b0, 1'b1, 1'b0, M_RUN | M_GRC | M_ROUT | M_ZIN);
      cyc(1'b0, 1'b1, 1'b1, 25'h0);
      cyc(1'b0, 1'b1, 1'b1, 25'h0);
      cyc(1'b1, 1'b1, 1'b0, 25'h0);
      exec_instr("add_after_reset", 32'h19890000, 0, 0, 1'b0, n);

      exec_instr("nop", {5'b11010, 27'h0}, 0, 0, 1'b0, n); lit("nop_latency", n, 3);
      exec_instr("unknown", {5'b11111, 27'h0}, 0, 0, 1'b0, n); lit("unknown_latency", n, 3);

      exec_instr("halt", {5'b11011, 27'h0}, 0, 0, 1'b0, n);
      tag = "halted";
      for (int i = 0; i < 5; i++) cyc(1'b1, i[0], i[1], 25'h0);
      instr = {5'b11010, 27'h0};
      cyc(1'b1, 1'b1, 1'b1, 25'h0);
      tag = "halt_reset";
      cyc(1'b0, 1'b0, 1'b0, 25'h0);
      cyc(1'b1, 1'b0, 1'b0, 25'h0);
      exec_instr("nop_after_halt", {5'b11010, 27'h0}, 0, 0, 1'b0, n);
      exec_instr("add_final", 32'h19890000, 0, 0, 1'b0, n);

      chk = 1'b0;
      @(negedge clock);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/control_seq.md
# control_seq

Hardwired control sequencer for the Mini SRC datapath. Steps through fetch, decode and execute T-states and drives every datapath strobe, including the `Gra/Grb/Grc/Rin/Rout/BAout/Cout` select controls consumed by the register select-and-encode logic. It sits between the instruction register and memory interface on one side and the bus/register-file strobes on the other. Memory accesses use a ready handshake.

## Interface
- No parameters.
- `clock` in 1: single system clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-low; sampled on the rising edge of `clock`.
- `instr` in 32: current IR contents; `[31:27]` opcode, `[26:23]` ra.
- `con` in 1: branch condition flag from the CON FF, valid from the cycle after `CONin`.
- `mem_ready` in 1: memory has completed the `Read`/`Write` access this cycle.
- `Gra`, `Grb`, `Grc`, `Rin`, `Rout`, `BAout`, `Cout` out 1 each: register select/encode controls.
- `PCout`, `PCin`, `IncPC`, `MARin`, `MDRin`, `MDRout`, `IRin`, `Yin`, `Zin`, `Zlowout`, `CONin` out 1 each: datapath strobes.
- `Read`, `Write` out 1 each: memory requests.
- `alu_op` out 4: ADD=0000, SUB=0001, AND=0010, OR=0011.
- `run` out 1: high while executing; low in reset and HALT.

## Operation
- States: RST, T0–T7, HALT. Outputs are decoded from the state register plus `instr[31:27]`. Any strobe not listed for a state is 0. `alu_op` is 0000 unless `Zin` is asserted.
- Fetch, common to all opcodes:
  - T0: `PCout`, `MARin`, `IncPC`, `Zin`.
  - T1: `Zlowout`, `PCin`, `Read`, `MDRin`.
  - T2: `MDRout`, `IRin`.
- T2 transitions to T3. For nop (11010) and for unknown opcodes, T2 transitions to T0 instead.
- R-type ALU (add 00011, sub 00100, and 00101, or 00110):
  - T3: `Grb`, `Rout`, `Yin`.
  - T4: `Grc`, `Rout`, `alu_op`, `Zin`.
  - T5: `Zlowout`, `Gra`, `Rin`; then T0.
- I-type ALU (addi 01100 ADD, andi 01101 AND, ori 01110 OR):
  - T3: `Grb`, `Rout`, `Yin`.
  - T4: `Cout`, `alu_op`, `Zin`.
  - T5: `Zlowout`, `Gra`, `Rin`; then T0.
- ldi (00001):
  - T3: `Grb`, `BAout`, `Yin`.
  - T4: `Cout`, ADD, `Zin`.
  - T5: `Zlowout`, `Gra`, `Rin`; then T0.
- ld (00000):
  - T3–T4 as ldi.
  - T5: `Zlowout`, `MARin`.
  - T6: `Read`, `MDRin`.
  - T7: `MDRout`, `Gra`, `Rin`; then T0.
- st (00010):
  - T3–T5 as ld.
  - T6: `Gra`, `Rout`, `MDRin` (`Read`=0, so MDR loads from the bus).
  - T7: `Write`; then T0.
- br (10010):
  - T3: `Gra`, `Rout`, `CONin`.
  - T4: `PCout`, `Yin`.
  - T5: `Cout`, ADD, `Zin`.
  - T6: if `con`=1, `Zlowout` and `PCin`; if `con`=0, no strobes. Then T0.
- halt (11011): T2 transitions to HALT. HALT holds with all strobes 0 and `run`=0 until reset.
- Exactly one of `Gra/Grb/Grc` is high in any cycle where `Rin`, `Rout` or `BAout` is high.

## Timing
- `reset`=0 at a rising edge: state becomes RST regardless of the current state, including mid-instruction or mid-handshake. In RST all outputs are 0 and `run`=0.
- First rising edge with `reset`=1: RST transitions to T0 and `run` goes to 1.
- Memory handshake, applies to T1, ld T6 and st T7:
  - The state holds, with `Read`/`Write` and the other strobes of that state held, for every edge at which `mem_ready`=0.
  - The state advances on the first edge at which `mem_ready`=1.
  - If `mem_ready` is 1 on the first cycle, the state lasts one cycle.
- `mem_ready` is ignored in all other states.
- Instruction latencies with zero memory wait:
  - nop: 3 cycles.
  - ALU, addi/andi/ori, ldi: 6 cycles.
  - br: 7 cycles.
  - ld, st: 8 cycles.
- Each memory wait cycle adds one cycle to the instruction.
- `con` is sampled only in br T6.
- `instr` is assumed stable from T3 to the end of the instruction. The opcode is decoded combinationally each cycle.

## Test plan
- Reset: hold `reset`=0 for 3 cycles mid-T4 of an add. Required: all outputs 0 and `run`=0 during reset; T0 strobes appear exactly 1 cycle after `reset`=1.
- add r3,r1,r2 (`instr`=0x19890000) with `mem_ready`=1. Required: T3 `Grb`+`Rout`+`Yin`; T4 `Grc`+`Rout`, `alu_op`=0000, `Zin`; T5 `Gra`+`Rin`; next fetch at cycle 6.
- ld with `mem_ready` held low for 2 cycles in T1 and in T6. Required: `Read` high for 3 cycles in each access; T7 `MDRout`+`Gra`+`Rin`; total 12 cycles.
- st: required T6 `Gra`+`Rout`+`MDRin` with `Read`=0; T7 `Write` held until `mem_ready`=1.
- br twice, with `con`=1 and with `con`=0 in T6. Required: `PCin`+`Zlowout` in T6 only when `con`=1; `CONin` in T3 in both cases.
- halt then nop: required `run`=0 and no strobes forever after halt T2; nop returns to T0 after T2; an unknown opcode (11111) behaves as nop.
